// File: rtl/phoneme_sample_player.sv
// Phoneme sample player: turns the divided sample-rate square wave into
// single-cycle ticks and, on each tick, fetches the next segment sample from
// ROM and presents it with a one-cycle valid strobe. A start/busy/done
// handshake frames each segment.
module phoneme_sample_player #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              tick_clk,
    input  logic              start,
    input  logic [ADDR_W-1:0] seg_base,
    input  logic [ADDR_W-1:0] seg_len,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    // wait counter spans 0..ROM_LAT, ROM_LAT is at most 4
    localparam int unsigned WAIT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_s1, r_s2, r_s3;
    logic [ADDR_W-1:0]   r_len, w_len_nxt;
    logic [ADDR_W-1:0]   r_cnt, w_cnt_nxt;
    logic [WAIT_W-1:0]   r_wait, w_wait_nxt;
    logic [ADDR_W-1:0]   r_rom_addr, w_rom_addr_nxt;
    logic [DATA_W-1:0]   r_sample, w_sample_nxt;
    logic                r_valid, w_valid_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_overrun, w_overrun_nxt;

    logic                w_tick;
    logic                w_pending;
    logic [ADDR_W-1:0]   w_cnt_inc;

    assign w_tick    = r_s2 & ~r_s3;
    assign w_pending = (r_wait != WAIT_W'(0));
    assign w_cnt_inc = r_cnt + ADDR_W'(1);

    assign rom_addr     = r_rom_addr;
    assign sample_out   = r_sample;
    assign sample_valid = r_valid;
    assign busy         = r_busy;
    assign done         = r_done;
    assign overrun      = r_overrun;

    // Two-flop synchroniser plus history flop for rising-edge detection
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= tick_clk;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_cnt      <= '0;
            r_wait     <= '0;
            r_rom_addr <= '0;
            r_sample   <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len_nxt;
            r_cnt      <= w_cnt_nxt;
            r_wait     <= w_wait_nxt;
            r_rom_addr <= w_rom_addr_nxt;
            r_sample   <= w_sample_nxt;
            r_valid    <= w_valid_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_overrun  <= w_overrun_nxt;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_len_nxt      = r_len;
        w_cnt_nxt      = r_cnt;
        w_wait_nxt     = r_wait;
        w_rom_addr_nxt = r_rom_addr;
        w_sample_nxt   = r_sample;
        w_valid_nxt    = 1'b0;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_overrun_nxt  = r_overrun;

        case (r_state)
            ST_IDLE: begin
                w_busy_nxt = 1'b0;
                w_wait_nxt = '0;
                if (start) begin
                    w_rom_addr_nxt = seg_base;
                    w_len_nxt      = seg_len;
                    w_cnt_nxt      = '0;
                    w_overrun_nxt  = 1'b0;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = (seg_len == '0) ? ST_DONE : ST_PLAY;
                end
            end
            ST_PLAY: begin
                w_busy_nxt = 1'b1;
                if (w_pending) begin
                    // a tick during an outstanding fetch is lost, not queued
                    if (w_tick) begin
                        w_overrun_nxt = 1'b1;
                    end
                    if (r_wait == WAIT_W'(ROM_LAT)) begin
                        w_sample_nxt   = rom_data;
                        w_valid_nxt    = 1'b1;
                        w_rom_addr_nxt = r_rom_addr + ADDR_W'(1);
                        w_cnt_nxt      = w_cnt_inc;
                        w_wait_nxt     = '0;
                        if (w_cnt_inc == r_len) begin
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_wait_nxt = r_wait + WAIT_W'(1);
                    end
                end else if (w_tick) begin
                    w_wait_nxt = WAIT_W'(1);
                end
            end
            ST_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_wait_nxt  = '0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_phoneme_sample_player.sv
// Bench for phoneme_sample_player: two instances (ROM latency 1 and 4) share
// the stimulus; a scoreboard queue per instance holds the expected samples.
module tb_phoneme_sample_player;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        tick_clk;
    logic        start;
    logic [15:0] seg_base;
    logic [15:0] seg_len;

    logic [15:0] rom_addr_a, rom_data_a, sample_out_a;
    logic        valid_a, busy_a, done_a, overrun_a;
    logic [15:0] rom_addr_b, rom_data_b, sample_out_b;
    logic        valid_b, busy_b, done_b, overrun_b;

    logic [15:0] pipe_a;
    logic [15:0] pipe_b [4];

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int tick_half = 0;
    int last_rise = 0;
    bit lat_chk = 1'b0;

    int strobes_a = 0, strobes_b = 0;
    int done_cnt_a = 0, done_cnt_b = 0;
    int done_cyc_a = 0, last_valid_a = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];

    typedef struct {
        logic [15:0] base;
        logic [15:0] len;
        int          exp_strobes;
        logic [15:0] exp_end_addr;
        logic [15:0] exp_last;
    } vec_t;

    vec_t tbl [3];

    phoneme_sample_player #(.ADDR_W(16), .DATA_W(16), .ROM_LAT(1)) u_dut_a (
        .clk_in(clk_in), .reset(reset), .tick_clk(tick_clk), .start(start),
        .seg_base(seg_base), .seg_len(seg_len), .rom_addr(rom_addr_a),
        .rom_data(rom_data_a), .sample_out(sample_out_a), .sample_valid(valid_a),
        .busy(busy_a), .done(done_a), .overrun(overrun_a)
    );

    phoneme_sample_player #(.ADDR_W(16), .DATA_W(16), .ROM_LAT(4)) u_dut_b (
        .clk_in(clk_in), .reset(reset), .tick_clk(tick_clk), .start(start),
        .seg_base(seg_base), .seg_len(seg_len), .rom_addr(rom_addr_b),
        .rom_data(rom_data_b), .sample_out(sample_out_b), .sample_valid(valid_b),
        .busy(busy_b), .done(done_b), .overrun(overrun_b)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // ROM model: ROM[i] = i + 0x100, latency 1 and 4 cycles
    always @(posedge clk_in) begin
        pipe_a    <= rom_addr_a + 16'h0100;
        pipe_b[0] <= rom_addr_b + 16'h0100;
        for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign rom_data_a = pipe_a;
    assign rom_data_b = pipe_b[3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Square-wave generator on tick_clk, half period in clk_in cycles
    initial begin
        int tcnt;
        tcnt = 0;
        tick_clk = 1'b0;
        forever begin
            @(negedge clk_in);
            if (tick_half != 0) begin
                tcnt++;
                if (tcnt >= tick_half) begin
                    tcnt = 0;
                    tick_clk = ~tick_clk;
                    if (tick_clk) last_rise = cyc;
                end
            end
        end
    end

    // Output monitor: pops scoreboard on each strobe, tracks done pulses
    always @(negedge clk_in) begin
        if (!reset) begin
            if (valid_a) begin
                strobes_a++;
                last_valid_a = cyc;
                if (qa.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL unexpected_strobe_a: got %h expected none", sample_out_a);
                end else begin
                    chk("sample_a", 32'(sample_out_a), 32'(qa.pop_front()));
                end
                if (lat_chk) chk("latency_a", 32'(cyc - last_rise), 32'd4);
            end
            if (valid_b) begin
                strobes_b++;
                if (qb.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL unexpected_strobe_b: got %h expected none", sample_out_b);
                end else begin
                    chk("sample_b", 32'(sample_out_b), 32'(qb.pop_front()));
                end
                if (lat_chk) chk("latency_b", 32'(cyc - last_rise), 32'd7);
            end
            if (done_a) begin
                done_cnt_a++;
                done_cyc_a = cyc;
            end
            if (done_b) done_cnt_b++;
        end
    end

    // Pulse start for one cycle, queue the expected samples, check busy rose
    task automatic start_seg(input logic [15:0] base, input logic [15:0] len);
        @(negedge clk_in);
        seg_base = base;
        seg_len  = len;
        start    = 1'b1;
        for (int i = 0; i < 32'(len); i++) begin
            qa.push_back(16'(32'(base) + i + 32'h100));
            qb.push_back(16'(32'(base) + i + 32'h100));
        end
        @(negedge clk_in);
        start = 1'b0;
        chk("busy_rise_a", 32'(busy_a), 32'd1);
        chk("busy_rise_b", 32'(busy_b), 32'd1);
    endtask

    task automatic wait_done(input int da0, input int db0, input string nm);
        int k;
        k = 0;
        while (!(done_cnt_a > da0 && done_cnt_b > db0) && k < 400) begin
            @(negedge clk_in);
            k++;
        end
        if (k >= 400) begin
            n_vec++; n_fail++;
            $display("FAIL %s_timeout: got done_a=%0d done_b=%0d expected one more each",
                     nm, done_cnt_a - da0, done_cnt_b - db0);
        end
        @(negedge clk_in);
    endtask

    initial begin
        int sa, sb, da, db, k;

        tbl[0] = '{16'h0010, 16'd3, 3, 16'h0013, 16'h0112};
        tbl[1] = '{16'hFFFE, 16'd4, 4, 16'h0002, 16'h0101};
        tbl[2] = '{16'h1234, 16'd2, 2, 16'h1236, 16'h1335};

        reset = 1'b1; start = 1'b0; seg_base = '0; seg_len = '0;
        repeat (3) @(negedge clk_in);
        chk("rst_addr_a",  32'(rom_addr_a), 32'd0);
        chk("rst_sample_a", 32'(sample_out_a), 32'd0);
        chk("rst_busy_a",  32'(busy_a), 32'd0);
        chk("rst_done_a",  32'(done_a), 32'd0);
        chk("rst_valid_b", 32'(valid_b), 32'd0);
        chk("rst_ovr_b",   32'(overrun_b), 32'd0);
        reset = 1'b0;
        tick_half = 4;
        repeat (12) @(negedge clk_in);
        lat_chk = 1'b1;

        // Table-driven segments at tick period 8
        for (int v = 0; v < 3; v++) begin
            sa = strobes_a; sb = strobes_b; da = done_cnt_a; db = done_cnt_b;
            start_seg(tbl[v].base, tbl[v].len);
            wait_done(da, db, "table");
            chk("strobes_a",  32'(strobes_a - sa), 32'(tbl[v].exp_strobes));
            chk("strobes_b",  32'(strobes_b - sb), 32'(tbl[v].exp_strobes));
            chk("end_addr_a", 32'(rom_addr_a), 32'(tbl[v].exp_end_addr));
            chk("end_addr_b", 32'(rom_addr_b), 32'(tbl[v].exp_end_addr));
            chk("last_a",     32'(sample_out_a), 32'(tbl[v].exp_last));
            chk("last_b",     32'(sample_out_b), 32'(tbl[v].exp_last));
            chk("busy_end_a", 32'(busy_a), 32'd0);
            chk("done_after_strobe_a", 32'(done_cyc_a - last_valid_a), 32'd1);
            chk("queue_a_empty", 32'(qa.size()), 32'd0);
            chk("ovr_a", 32'(overrun_a), 32'd0);
            chk("ovr_b", 32'(overrun_b), 32'd0);
        end

        // Zero-length segment: busy one cycle, done two cycles after start
        sa = strobes_a; da = done_cnt_a;
        start_seg(16'h0500, 16'd0);
        @(negedge clk_in);
        chk("zero_done_a", 32'(done_a), 32'd1);
        chk("zero_busy_a", 32'(busy_a), 32'd0);
        chk("zero_done_b", 32'(done_b), 32'd1);
        @(negedge clk_in);
        chk("zero_done_fall_a", 32'(done_a), 32'd0);
        repeat (10) @(negedge clk_in);
        chk("zero_strobes_a", 32'(strobes_a - sa), 32'd0);
        chk("zero_hold_a", 32'(sample_out_a), 32'h1335);

        // Start while busy is ignored
        sa = strobes_a; da = done_cnt_a; db = done_cnt_b;
        start_seg(16'h0010, 16'd3);
        k = 0;
        while (strobes_a == sa && k < 100) begin
            @(negedge clk_in);
            k++;
        end
        chk("first_strobe_seen", 32'(strobes_a - sa), 32'd1);
        seg_base = 16'h0040; seg_len = 16'd5; start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        wait_done(da, db, "ignored_start");
        chk("ign_strobes_a", 32'(strobes_a - sa), 32'd3);
        chk("ign_addr_a", 32'(rom_addr_a), 32'h0013);
        chk("ign_addr_b", 32'(rom_addr_b), 32'h0013);

        // Overrun: tick period 2 outruns the 4-cycle ROM of instance b
        lat_chk = 1'b0;
        tick_half = 1;
        da = done_cnt_a; db = done_cnt_b;
        start_seg(16'h0020, 16'd3);
        wait_done(da, db, "overrun");
        chk("ovr_set_b",  32'(overrun_b), 32'd1);
        chk("ovr_clr_a",  32'(overrun_a), 32'd0);
        chk("ovr_addr_b", 32'(rom_addr_b), 32'h0023);
        tick_half = 4;
        repeat (10) @(negedge clk_in);
        chk("ovr_sticky_b", 32'(overrun_b), 32'd1);
        lat_chk = 1'b1;
        da = done_cnt_a; db = done_cnt_b;
        start_seg(16'h0030, 16'd2);
        chk("ovr_cleared_b", 32'(overrun_b), 32'd0);
        wait_done(da, db, "after_overrun");
        chk("ovr_stay_clr_b", 32'(overrun_b), 32'd0);

        // Reset mid-playback with tick_clk toggling
        lat_chk = 1'b0;
        tick_half = 1;
        da = done_cnt_a;
        start_seg(16'h0050, 16'd6);
        repeat (5) @(negedge clk_in);
        @(posedge clk_in);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_addr_a",  32'(rom_addr_a), 32'd0);
        chk("mid_rst_busy_a",  32'(busy_a), 32'd0);
        chk("mid_rst_busy_b",  32'(busy_b), 32'd0);
        chk("mid_rst_sample_a", 32'(sample_out_a), 32'd0);
        chk("mid_rst_ovr_b",   32'(overrun_b), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk("rst_hold_valid_a", 32'(valid_a), 32'd0);
            chk("rst_hold_valid_b", 32'(valid_b), 32'd0);
        end
        reset = 1'b0;
        qa.delete();
        qb.delete();
        repeat (20) @(negedge clk_in);
        chk("no_done_after_rst", 32'(done_cnt_a - da), 32'd0);
        chk("idle_after_rst_a", 32'(busy_a), 32'd0);

        // Player returns to normal operation from IDLE
        tick_half = 4;
        repeat (10) @(negedge clk_in);
        lat_chk = 1'b1;
        da = done_cnt_a; db = done_cnt_b;
        start_seg(16'h0060, 16'd1);
        wait_done(da, db, "post_reset");
        chk("post_rst_addr_a", 32'(rom_addr_a), 32'h0061);
        chk("post_rst_last_b", 32'(sample_out_b), 32'h0160);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/phoneme_sample_player.md
Name: phoneme_sample_player

Overview:
Downstream consumer of the divided sample-rate clock. Treats the divider's square-wave output as data, not as a clock: it synchronises the wave, edge-detects it into single-cycle sample ticks, and on each tick fetches the next sample of a phoneme segment from sample ROM. Each fetched sample is presented to the audio output stage with a one-cycle valid strobe. A start/busy/done handshake with the phoneme sequencer frames each segment.

Parameters:
ADDR_W, 16, sample ROM address width; address arithmetic is modulo 2^ADDR_W
DATA_W, 16, sample width
ROM_LAT, 1, ROM read latency in clk_in cycles (1..4)

Ports:
clk_in  input  1  system clock; every flop is on its rising edge
reset  input  1  asynchronous, active-high reset
tick_clk  input  1  divided sample-rate square wave from the clock divider, sampled as data
start  input  1  one-cycle request to play a segment; honoured only in IDLE
seg_base  input  ADDR_W  first ROM address of the segment, latched on an accepted start
seg_len  input  ADDR_W  number of samples in the segment, latched on an accepted start
rom_addr  output  ADDR_W  registered ROM read address
rom_data  input  DATA_W  ROM read data, valid ROM_LAT cycles after rom_addr changes
sample_out  output  DATA_W  last sample played, held between strobes
sample_valid  output  1  one-cycle strobe: sample_out updated this cycle
busy  output  1  high from an accepted start until done
done  output  1  one-cycle pulse: segment finished
overrun  output  1  sticky: a tick was dropped; cleared by an accepted start or by reset

Behaviour:
- Reset (asynchronous): every output and internal register goes to 0, state goes to IDLE. Reset mid-playback aborts immediately; no done pulse is issued.
- Tick path: tick_clk passes through two synchronising flops s1, s2 and a history flop s3. tick = s2 & ~s3. A rising edge on tick_clk produces tick on the 3rd clk_in edge after it. Falling edges do nothing.
- Registers: len_r (latched length), cnt (samples played, ADDR_W bits), and wait_ctr (counts 0..ROM_LAT while a fetch is pending).
- State IDLE: busy=0. On start:
  - latch rom_addr<=seg_base, len_r<=seg_len, cnt<=0, overrun<=0.
  - if seg_len==0, go to DONE; otherwise go to PLAY.
  - busy rises the cycle after start.
- State PLAY: busy=1.
  - On a tick with no fetch pending: begin a fetch and load wait_ctr. rom_addr is held stable during the fetch.
  - After ROM_LAT cycles: sample_out<=rom_data, sample_valid=1 for one cycle, rom_addr<=rom_addr+1 (wraps 2^ADDR_W-1 -> 0), cnt<=cnt+1.
  - If cnt+1==len_r, go to DONE in the same cycle as that final strobe.
- Tick arriving while a fetch is pending: dropped; overrun<=1. No queuing.
- State DONE: lasts one cycle. done=1, busy=0, then return to IDLE.
- Ignored inputs: start is ignored in PLAY and DONE. Ticks are ignored in IDLE and DONE.
- Timing:
  - rising edge of tick_clk to sample_valid = 3+ROM_LAT clk_in cycles.
  - the first sample played is ROM[seg_base]; no sample is emitted at start.
- sample_out holds its last value through IDLE; it is cleared only by reset.
- A change of tick_clk while in IDLE does not create a tick on entry to PLAY (s3 tracks s2 continuously).

Test Plan:
- Reset: assert reset mid-cycle with tick_clk toggling -> all outputs 0 asynchronously; no sample_valid while reset is held.
- Basic segment, ROM_LAT=1, ROM[i]=i+0x100, seg_base=0x10, seg_len=3, tick_clk period 8 clk_in -> strobes with samples 0x110, 0x111, 0x112, each 4 cycles after a tick_clk rise; done pulses with the third strobe's state exit; busy 1->0.
- Zero length, seg_len=0 -> no sample_valid; done pulses 2 cycles after start; busy high for 1 cycle.
- Start while busy: second start (seg_base=0x40) during PLAY -> ignored; addresses continue 0x10..0x12 only.
- Wrap: seg_base=0xFFFE, seg_len=4 -> rom_addr sequence FFFE, FFFF, 0000, 0001; 4 strobes then done.
- Overrun: ROM_LAT=4, tick_clk period 2 clk_in (divider value 0) -> overrun=1, stays set after done, cleared by the next accepted start; reset asserted mid-PLAY -> no done, state IDLE.
